checksum_engine: RTL and testbench

- Parametrised, self-checking reduction engine; successor to the fixed 16-entry sum checker.
- Holds a host-loadable word memory and reduces a programmable-length prefix of it in one of three modes: modular sum, XOR, or ones-complement sum.
- Compares the result against a supplied expected value and reports done/pass/overflow on ports, so a test harness or runtime bench can sequence many checks without `$finish`.

---
 rtl/checksum_engine.sv | 167 ++++++++++++++++
 tb/tb_checksum_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/checksum_engine.sv
// Reduction engine: loads words into a local memory, then sums, XORs or ones-complement-sums
// a prefix of them and compares the result against a reference value.
module checksum_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ACC_WIDTH-1:0]  expected,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  overflow,
  output logic [ACC_WIDTH-1:0]  result
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, CHECK} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [1:0]            mode_q, mode_d;
  logic [ACC_WIDTH-1:0]  exp_q, exp_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]  result_q, result_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic [ADDR_WIDTH:0]   len_clamped;
  logic [ACC_WIDTH-1:0]  d_ext;
  logic [ACC_WIDTH:0]    sum_ext;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic                  carry;

  // Memory is deliberately not reset; writes are only honoured while idle.
  always_ff @(posedge clock) begin
    if (wr_en && (state_q == IDLE)) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  always_comb begin
    len_clamped = ((len == '0) || (len > DEPTH_L)) ? DEPTH_L : len;
    d_ext       = ACC_WIDTH'(rd_data_q);
    sum_ext     = {1'b0, acc_q} + {1'b0, d_ext};
    carry       = 1'b0;
    case (mode_q)
      2'b01:   acc_next = acc_q ^ d_ext;
      2'b10:   acc_next = sum_ext[ACC_WIDTH-1:0] + ACC_WIDTH'(sum_ext[ACC_WIDTH]);
      default: begin
        acc_next = sum_ext[ACC_WIDTH-1:0];
        carry    = sum_ext[ACC_WIDTH];
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    mode_d     = mode_q;
    exp_d      = exp_q;
    acc_d      = acc_q;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    rd_en      = 1'b0;
    rd_addr    = cnt_q[ADDR_WIDTH-1:0];

    // A read issued last cycle has its word on rd_data_q now.
    if (rd_valid_q) begin
      acc_d = acc_next;
      ovf_d = ovf_q | carry;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          len_d   = len_clamped;
          mode_d  = mode;
          exp_d   = expected;
          acc_d   = '0;
          ovf_d   = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        rd_en      = 1'b1;
        rd_valid_d = 1'b1;
        cnt_d      = cnt_q + ONE_L;
        if ((cnt_q + ONE_L) == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = CHECK;
      end
      CHECK: begin
        result_d = acc_q;
        pass_d   = (acc_q == exp_q);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      mode_q     <= '0;
      exp_q      <= '0;
      acc_q      <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      exp_q      <= exp_d;
      acc_q      <= acc_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign overflow = ovf_q;
  assign result   = result_q;

endmodule

// File: tb/tb_checksum_engine.sv
// Bench for checksum_engine: vector table of runs plus hand sequences for write/start
// collisions and mid-run reset; results flow through an expected-value queue.
module tb_checksum_engine;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int ACC_W = 32;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             start = 1'b0;
  logic [1:0]       mode = '0;
  logic [AW:0]      len = '0;
  logic [ACC_W-1:0] expected = '0;
  logic             busy, done, pass, overflow;
  logic [ACC_W-1:0] result;

  checksum_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACC_W)) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .mode(mode), .len(len), .expected(expected), .busy(busy), .done(done),
    .pass(pass), .overflow(overflow), .result(result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]       mode;
    logic [AW:0]      len;
    logic [ACC_W-1:0] exp_in;
    logic [ACC_W-1:0] res;
    logic             pass;
    logic             ovf;
    int               cycles;
  } vec_t;

  typedef struct {
    logic [ACC_W-1:0] res;
    logic             pass;
    logic             ovf;
  } sb_t;

  sb_t              sb_q[$];
  vec_t             vecs[10];
  int               total = 0;
  int               bad = 0;
  int               done_count = 0;
  logic [ACC_W-1:0] last_result = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    sb_t e;
    if (reset_n && done) begin
      done_count++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 result=%0h, want no done", result);
      end else begin
        e = sb_q.pop_front();
        checkOutput("result", 64'(result), 64'(e.res));
        checkOutput("pass", 64'(pass), 64'(e.pass));
        checkOutput("overflow", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  task automatic writeMem(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // Drives start on one negedge (optionally with a same-cycle write to mem[0]) and, when
  // inject >= 0, pulses start plus a write of 99 to mem[0] that many cycles into the run.
  task automatic applyStimulus(input vec_t v, input bit with_write, input logic [DW-1:0] wval,
                               input int inject);
    int n;
    int busy_cycles;
    @(negedge clock);
    mode = v.mode;
    len = v.len;
    expected = v.exp_in;
    start = 1'b1;
    if (with_write) begin
      wr_en = 1'b1;
      wr_addr = '0;
      wr_data = wval;
    end
    sb_q.push_back('{res: v.res, pass: v.pass, ovf: v.ovf});
    @(negedge clock);
    start = 1'b0;
    wr_en = 1'b0;
    checkOutput("busy_on", 64'(busy), 64'd1);
    checkOutput("pass_cleared", 64'(pass), 64'd0);
    checkOutput("ovf_cleared", 64'(overflow), 64'd0);
    checkOutput("result_held", 64'(result), 64'(last_result));
    n = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && n < 100) begin
      if (n == inject) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = 32'd99;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      @(negedge clock);
      n++;
      if (busy) busy_cycles++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    checkOutput("latency", 64'(n), 64'(v.cycles));
    checkOutput("busy_cycles", 64'(busy_cycles), 64'(v.cycles));
    last_result = v.res;
    @(negedge clock);
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    checkOutput("pass_held", 64'(pass), 64'(v.pass));
  endtask

  initial begin
    int d0;
    vec_t v;
    vecs[0] = '{2'd0, 5'd16, 32'd120, 32'd120, 1'b1, 1'b0, 18};
    vecs[1] = '{2'd1, 5'd0,  32'd0,   32'd0,   1'b1, 1'b0, 18};
    vecs[2] = '{2'd1, 5'd3,  32'd3,   32'd3,   1'b1, 1'b0, 5};
    vecs[3] = '{2'd0, 5'd16, 32'd121, 32'd120, 1'b0, 1'b0, 18};
    vecs[4] = '{2'd3, 5'd4,  32'd6,   32'd6,   1'b1, 1'b0, 6};
    vecs[5] = '{2'd2, 5'd16, 32'd120, 32'd120, 1'b1, 1'b0, 18};
    vecs[6] = '{2'd0, 5'd17, 32'd120, 32'd120, 1'b1, 1'b0, 18};
    vecs[7] = '{2'd0, 5'd1,  32'd0,   32'd0,   1'b1, 1'b0, 3};
    vecs[8] = '{2'd1, 5'd5,  32'd4,   32'd4,   1'b1, 1'b0, 7};
    vecs[9] = '{2'd0, 5'd31, 32'd120, 32'd120, 1'b1, 1'b0, 18};

    repeat (2) @(negedge clock);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_pass", 64'(pass), 64'd0);
    checkOutput("reset_ovf", 64'(overflow), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) writeMem(AW'(i), DW'(i));

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], 1'b0, '0, -1);

    $display("[TB] carry and end-around carry");
    writeMem(4'd0, 32'hFFFF_FFFF);
    writeMem(4'd1, 32'hFFFF_FFFF);
    v = '{2'd0, 5'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, 1'b1, 4};
    applyStimulus(v, 1'b0, '0, -1);
    v = '{2'd2, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4};
    applyStimulus(v, 1'b0, '0, -1);
    writeMem(4'd0, 32'd0);
    writeMem(4'd1, 32'd1);

    $display("[TB] write and start in the same cycle");
    v = '{2'd0, 5'd1, 32'd5, 32'd5, 1'b1, 1'b0, 3};
    applyStimulus(v, 1'b1, 32'd5, -1);
    writeMem(4'd0, 32'd0);

    $display("[TB] start and write while busy");
    d0 = done_count;
    v = '{2'd0, 5'd16, 32'd120, 32'd120, 1'b1, 1'b0, 18};
    applyStimulus(v, 1'b0, '0, 3);
    repeat (5) @(negedge clock);
    checkOutput("single_done", 64'(done_count - d0), 64'd1);
    checkOutput("no_restart", 64'(busy), 64'd0);
    v = '{2'd0, 5'd1, 32'd0, 32'd0, 1'b1, 1'b0, 3};
    applyStimulus(v, 1'b0, '0, -1);

    $display("[TB] reset mid-run");
    @(negedge clock);
    mode = 2'd0;
    len = 5'd16;
    expected = 32'd120;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_pass", 64'(pass), 64'd0);
    checkOutput("midrst_result", 64'(result), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    last_result = '0;
    d0 = done_count;
    repeat (25) @(negedge clock);
    checkOutput("no_done_after_reset", 64'(done_count - d0), 64'd0);
    v = '{2'd0, 5'd16, 32'd120, 32'd120, 1'b1, 1'b0, 18};
    applyStimulus(v, 1'b0, '0, -1);

    checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
